// File: rtl/nios_system_mem_bist_pkg.sv
// Shared definitions for the memory BIST master: FSM states, pattern increment
// and result-counter width.
package nios_system_mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0] GOLDEN_INC = 32'h9E3779B9;
    localparam int unsigned ERR_W      = 16;

endpackage

// File: rtl/nios_system_mem_bist_pattern.sv
// Pattern generator: p(0)=seed, p(i+1)=p(i)+golden increment. One instance feeds
// write data, another tracks the expected read-back value.
module nios_system_mem_bist_pattern
    import nios_system_mem_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              step,
    output logic [DATA_W-1:0] value
);

    localparam logic [DATA_W-1:0] INC = DATA_W'(GOLDEN_INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= value + INC;
        end
    end

endmodule

// File: rtl/nios_system_mem_bist_master.sv
// Avalon-MM BIST master: writes a pattern over a word range, reads it back with
// pipelined reads and reports pass/fail, mismatch count and first failing address.
module nios_system_mem_bist_master
    import nios_system_mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W+1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    localparam int unsigned OUT_W = 3;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   issue_addr;
    logic [ADDR_W-1:0]   cmp_addr;
    logic [ADDR_W:0]     issue_cnt;
    logic [OUT_W-1:0]    outstanding;

    logic                start_accept;
    logic                wr_acc;
    logic                rd_acc;
    logic                rd_valid;
    logic                mismatch;
    logic [ADDR_W:0]     issue_cnt_next;
    logic [OUT_W-1:0]    outstanding_next;
    logic [ERR_W-1:0]    err_next;
    logic [DATA_W-1:0]   expect_data;

    assign avm_address    = {issue_addr, 2'b00};
    assign avm_byteenable = (avm_read || avm_write) ? '1 : '0;

    always_comb begin
        start_accept     = start && (state == ST_IDLE);
        wr_acc           = avm_write && !avm_waitrequest;
        rd_acc           = avm_read && !avm_waitrequest;
        // Data arriving with nothing in flight (e.g. after an aborting reset) is dropped.
        rd_valid         = avm_readdatavalid && (outstanding != '0) &&
                           ((state == ST_READ) || (state == ST_DRAIN));
        issue_cnt_next   = issue_cnt + (ADDR_W+1)'(wr_acc || rd_acc);
        outstanding_next = outstanding + OUT_W'(rd_acc) - OUT_W'(rd_valid);
        mismatch         = rd_valid && (avm_readdata != expect_data);
        err_next         = err_count;
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    nios_system_mem_bist_pattern #(.DATA_W(DATA_W)) u_issue_pat (
        .clk   (clk),
        .reset (reset),
        .load  (start_accept),
        .seed  (seed),
        .step  (wr_acc),
        .value (avm_writedata)
    );

    nios_system_mem_bist_pattern #(.DATA_W(DATA_W)) u_cmp_pat (
        .clk   (clk),
        .reset (reset),
        .load  (start_accept),
        .seed  (seed),
        .step  (rd_valid),
        .value (expect_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            base_q         <= '0;
            len_q          <= '0;
            issue_addr     <= '0;
            cmp_addr       <= '0;
            issue_cnt      <= '0;
            outstanding    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        len_q          <= length;
                        issue_addr     <= base_addr;
                        cmp_addr       <= base_addr;
                        issue_cnt      <= '0;
                        outstanding    <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        if (length == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state     <= ST_WRITE;
                            busy      <= 1'b1;
                            avm_write <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_acc) begin
                        if (issue_cnt_next == len_q) begin
                            avm_write  <= 1'b0;
                            avm_read   <= 1'b1;
                            state      <= ST_READ;
                            issue_addr <= base_q;
                            issue_cnt  <= '0;
                        end else begin
                            issue_addr <= issue_addr + ADDR_W'(1);
                            issue_cnt  <= issue_cnt_next;
                        end
                    end
                end
                ST_READ: begin
                    outstanding <= outstanding_next;
                    issue_cnt   <= issue_cnt_next;
                    if (rd_acc) begin
                        issue_addr <= issue_addr + ADDR_W'(1);
                    end
                    // Read strobe is registered, so decide it from next-cycle counts.
                    if (issue_cnt_next == len_q) begin
                        avm_read <= 1'b0;
                        state    <= ST_DRAIN;
                    end else begin
                        avm_read <= (outstanding_next < OUT_W'(MAX_OUTSTANDING));
                    end
                end
                ST_DRAIN: begin
                    outstanding <= outstanding_next;
                    if (outstanding_next == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_next == '0);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (rd_valid) begin
                cmp_addr  <= cmp_addr + ADDR_W'(1);
                err_count <= err_next;
                if (mismatch && (err_count == '0)) begin
                    first_err_addr <= cmp_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_system_mem_bist_master.sv
// Bench for the memory BIST master: Avalon slave model with stalls, configurable
// read latency and an injectable bit fault, checked against an arithmetic reference.
module tb_nios_system_mem_bist_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [9:0]  first_err_addr;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    nios_system_mem_bist_master #(
        .ADDR_W(10), .DATA_W(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state for the current run.
    int unsigned m_base, m_len;
    logic [31:0] m_seed;
    bit          fault_en, stall_mode, rand_stall;
    int          lat = 1;
    int unsigned wr_cnt, rd_cnt, rdv_cnt, req_cycles;
    int          last_rdv_cyc;

    logic [31:0] mem [1024];

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_item_t;
    rd_item_t rq[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(int unsigned i);
        return m_seed + 32'h9E3779B9 * i;
    endfunction

    function automatic logic [9:0] waddr(int unsigned i);
        return 10'((m_base + i) % 1024);
    endfunction

    // Slave model: decides waitrequest and read data at the falling edge so the
    // DUT samples them on the following rising edge.
    bit          held = 0;
    int          stall_left = 0;
    logic [11:0] h_addr;
    logic [31:0] h_data;
    logic        h_wr;
    always @(negedge clk) begin : slave
        logic [31:0] d;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rq[0].data;
            void'(rq.pop_front());
            rdv_cnt++;
            last_rdv_cyc = cyc;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end

        if (avm_read || avm_write) begin
            req_cycles++;
            check("rw_exclusive", {63'd0, avm_read & avm_write}, 64'd0);
            if (held) begin
                check("hold_addr", avm_address, h_addr);
                check("hold_kind", avm_write, h_wr);
                if (h_wr) check("hold_data", avm_writedata, h_data);
            end else begin
                stall_left = 0;
                if (stall_mode && avm_write && wr_cnt == 0) stall_left = 3;
                else if (stall_mode && avm_read && rd_cnt == 1) stall_left = 3;
                else if (rand_stall && $urandom_range(0, 3) == 0) stall_left = $urandom_range(1, 2);
            end
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                held   = 1;
                h_addr = avm_address;
                h_wr   = avm_write;
                h_data = avm_writedata;
            end else begin
                avm_waitrequest = 1'b0;
                held = 0;
                check("byteenable", avm_byteenable, 4'hF);
                if (avm_write) begin
                    check("wr_addr", avm_address, {waddr(wr_cnt), 2'b00});
                    check("wr_data", avm_writedata, pat(wr_cnt));
                    mem[avm_address[11:2]] = avm_writedata;
                    wr_cnt++;
                end else begin
                    check("rd_addr", avm_address, {waddr(rd_cnt), 2'b00});
                    d = mem[avm_address[11:2]];
                    if (fault_en && avm_address[11:2] == 10'h005) d = d ^ 32'd1;
                    rq.push_back('{d, cyc + lat});
                    rd_cnt++;
                end
            end
        end else begin
            if (held) check("hold_req", 64'd0, 64'd1);
            held = 0;
            avm_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    task automatic run_test(string name, int unsigned base, int unsigned len,
                            logic [31:0] s, bit extra_start);
        int          waited;
        int unsigned exp_err;
        logic [9:0]  exp_first;
        m_base = base; m_len = len; m_seed = s;
        wr_cnt = 0; rd_cnt = 0; rdv_cnt = 0; req_cycles = 0; last_rdv_cyc = -100;
        exp_err = 0; exp_first = '0;
        for (int unsigned i = 0; i < len; i++) begin
            if (fault_en && ((base + i) % 1024) == 5) begin
                exp_err++;
                exp_first = 10'h005;
            end
        end
        @(negedge clk);
        start = 1'b1; base_addr = base[9:0]; length = len[10:0]; seed = s;
        @(negedge clk);
        start = 1'b0;
        if (len > 0) begin
            check({name, "_busy"}, busy, 1'b1);
            check({name, "_pass_clr"}, pass, 1'b0);
        end
        if (extra_start) begin
            start = 1'b1; base_addr = base[9:0] + 10'd7; length = 11'd3; seed = ~s;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (!done && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_done"}, done, 1'b1);
        check({name, "_pass"}, pass, (exp_err == 0));
        check({name, "_err"}, err_count, exp_err);
        check({name, "_first"}, first_err_addr, exp_first);
        check({name, "_busy_done"}, busy, 1'b0);
        check({name, "_nwr"}, wr_cnt, len);
        check({name, "_nrd"}, rd_cnt, len);
        if (len > 0) check({name, "_done_lat"}, 64'(cyc - last_rdv_cyc), 64'd1);
        else         check({name, "_no_bus"}, req_cycles, 0);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 1'b0);
        check({name, "_pass_hold"}, pass, (exp_err == 0));
    endtask

    initial begin
        int waited;
        for (int unsigned i = 0; i < 1024; i++) mem[i] = $urandom;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        fault_en = 0; stall_mode = 0; rand_stall = 0; lat = 1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, pass}, 3'b000);
        check("rst_err", err_count, 16'd0);
        check("rst_first", first_err_addr, 10'd0);
        check("rst_bus", {avm_read, avm_write, avm_byteenable, avm_address}, '0);
        check("rst_wdata", avm_writedata, 32'd0);
        reset = 1'b0;

        run_test("t1", 0, 4, 32'd0, 1);
        check("t1_mem0", mem[0], 32'h00000000);
        check("t1_mem1", mem[1], 32'h9E3779B9);
        check("t1_mem2", mem[2], 32'h3C6EF372);
        check("t1_mem3", mem[3], 32'hDAA66D2B);

        run_test("t2_wrap", 10'h3FE, 4, $urandom, 0);

        stall_mode = 1;
        run_test("t3_stall", 10'h020, 6, $urandom, 0);
        stall_mode = 0;

        fault_en = 1;
        run_test("t4_fault", 0, 8, $urandom, 0);
        fault_en = 0;

        run_test("t5_len0", 10'h100, 0, $urandom, 0);

        rand_stall = 1;
        for (int unsigned k = 0; k < 6; k++) begin
            fault_en = bit'($urandom_range(0, 1));
            lat = $urandom_range(1, 3);
            run_test("rnd", $urandom_range(0, 1023), $urandom_range(1, 48), $urandom, 0);
        end
        fault_en = 0;
        lat = 1;
        run_test("full", $urandom_range(0, 1023), 1024, $urandom, 0);
        rand_stall = 0;

        // Abort with two reads in flight.
        lat = 3;
        m_base = 10'h040; m_len = 16; m_seed = $urandom;
        wr_cnt = 0; rd_cnt = 0; rdv_cnt = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 10'h040; length = 11'd16; seed = m_seed;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        #1;
        while (!(rd_cnt >= 2 && rd_cnt - rdv_cnt == 2) && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("t6_reach_out2", 64'(rd_cnt - rdv_cnt), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_bus", {avm_read, avm_write, busy}, 3'b000);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_late_done", done, 1'b0);
        check("t6_late_err", err_count, 16'd0);
        waited = 0;
        while (rq.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        lat = 1;
        run_test("t6_after", 10'h200, 2, $urandom, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
